// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage that sits directly upstream of the instruction
// memory. It owns the program counter, which is a word index that advances by
// one per instruction, and drives that counter into the memory. The memory
// reads on the negedge. The returned word is captured on the next posedge into
// the IF/ID register, together with the PC that produced it.
//
// The stage handles stalls from decode and branch/jump redirects. It halts
// when fetch runs past the last memory word.
//
// Build option:
//   FETCH_PERF_EN  When defined, adds the FetchCount and BubbleCount
//                  performance counters.
//
// Parameters:
//   RESET_PC      PC loaded on reset (word index)
//   MEM_DEPTH     number of instruction words; legal PC range 0..MEM_DEPTH-1
//
// Ports:
//   Clk           in   1   clock; all state changes on posedge
//   Reset         in   1   synchronous reset, active-high
//   Stall         in   1   hold PC and IF/ID contents (hazard from decode)
//   BranchTaken   in   1   redirect to BranchTarget this cycle
//   BranchTarget  in   32  branch target word index
//   Jump          in   1   redirect to JumpTarget (wins over BranchTaken)
//   JumpTarget    in   32  jump target word index
//   InstrIn       in   32  memory word for the current PC
//   PC            out  32  current fetch PC, fed to memory
//   IfIdInstr     out  32  captured instruction
//   IfIdPC        out  32  PC of the captured instruction
//   IfIdValid     out  1   IF/ID holds a real instruction
//   Halted        out  1   fetch FSM is in HALT
//   FetchCount    out  32  (FETCH_PERF_EN) number of advance edges
//   BubbleCount   out  32  (FETCH_PERF_EN) edges that loaded IfIdValid=0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstrIn,
  output logic [31:0] PC,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPC,
  output logic        IfIdValid,
`ifdef FETCH_PERF_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
`endif
  output logic        Halted
);

  // FSM encoding
  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  // Address bounds, expressed at the PC width
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);

  // State registers
  logic        r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic        r_ifid_valid;

  // Next-state values and decoded per-edge actions
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_advance;
  logic        w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_ifid_instr_next;
  logic [31:0] w_ifid_pc_next;
  logic        w_ifid_valid_next;

  // Jump has priority over a simultaneous taken branch.
  assign w_redirect = Jump | BranchTaken;
  assign w_target   = Jump ? JumpTarget : BranchTarget;

  // Advancing happens only in RUN, with no redirect and no stall.
  assign w_advance  = !w_redirect && (r_state == ST_RUN) && !Stall;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_pc_next    = r_ifid_pc;
    w_ifid_valid_next = r_ifid_valid;

    if (w_redirect) begin
      // Squash the wrong-path fetch. An out-of-range target parks the FSM
      // in HALT, with the PC left at the target for visibility. IF/ID
      // contents are don't-care here, so they are left untouched.
      w_pc_next         = w_target;
      w_ifid_valid_next = 1'b0;
      w_state_next      = (w_target < DEPTH_W) ? ST_RUN : ST_HALT;
    end else if (r_state == ST_HALT) begin
      // Stall is ignored while halted; only the valid bit drops.
      w_ifid_valid_next = 1'b0;
    end else if (!Stall) begin
      w_ifid_instr_next = InstrIn;
      w_ifid_pc_next    = r_pc;
      w_ifid_valid_next = 1'b1;
      if (r_pc == LAST_PC) begin
        // The last word has been fetched. Do not wrap to 0.
        w_state_next = ST_HALT;
      end else begin
        w_pc_next = r_pc + 32'd1;
      end
    end
    // A stall in RUN holds everything: the defaults above cover it.
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_pc    <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pc    <= w_ifid_pc_next;
      r_ifid_valid <= w_ifid_valid_next;
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters. A bubble is any edge that loads IfIdValid=0,
  // which covers redirects and edges spent in HALT. Stall edges count as
  // neither a fetch nor a bubble. Both counters wrap naturally at 2^32.
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;
  logic        w_bubble;

  assign w_bubble = w_redirect || (r_state == ST_HALT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_advance) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_bubble) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign FetchCount  = r_fetch_count;
  assign BubbleCount = r_bubble_count;
`else
  // Without the counters, w_advance is only used for documentation of
  // intent; keep it referenced so the default build has no dangling net.
  logic w_unused;
  assign w_unused = w_advance;
`endif

  assign PC        = r_pc;
  assign IfIdInstr = r_ifid_instr;
  assign IfIdPC    = r_ifid_pc;
  assign IfIdValid = r_ifid_valid;
  assign Halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit with MEM_DEPTH=32 and RESET_PC=0.
//
// The instruction memory is an array of random words. The reference model
// applies the fetch rules directly to a handful of variables: reset, then
// redirect, then halt, then stall, then advance. Every edge, after the
// posedge, each DUT output is compared with the model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int DEPTH = 32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPC;
  logic        IfIdValid;
  logic        Halted;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  fetch_unit #(.RESET_PC(32'd0), .MEM_DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .InstrIn      (InstrIn),
    .PC           (PC),
    .IfIdInstr    (IfIdInstr),
    .IfIdPC       (IfIdPC),
    .IfIdValid    (IfIdValid),
`ifdef FETCH_PERF_EN
    .FetchCount   (FetchCount),
    .BubbleCount  (BubbleCount),
`endif
    .Halted       (Halted)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: out-of-range addresses return a marker word.
  logic [31:0] mem [DEPTH];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'(DEPTH)) return mem[addr[4:0]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb InstrIn = mem_word(PC);

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_valid;
  logic        m_halted;
  logic        m_known;   // IF/ID contents are defined (not post-redirect)
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one posedge using the inputs present at that edge.
  task automatic model_edge();
    logic [31:0] tgt;
    if (Reset) begin
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_halted = 0;
      m_known = 1; m_fetch = 0; m_bubble = 0;
    end else if (Jump || BranchTaken) begin
      tgt      = Jump ? JumpTarget : BranchTarget;
      m_pc     = tgt;
      m_valid  = 0;
      m_known  = 0;
      m_halted = !(tgt < 32'(DEPTH));
      m_bubble++;
    end else if (m_halted) begin
      m_valid = 0;
      m_bubble++;
    end else if (!Stall) begin
      m_instr = mem_word(m_pc);
      m_ifpc  = m_pc;
      m_valid = 1;
      m_known = 1;
      m_fetch++;
      if (m_pc == 32'(DEPTH - 1)) m_halted = 1;
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("valid", {31'd0, IfIdValid}, {31'd0, m_valid});
    chk("halted", {31'd0, Halted}, {31'd0, m_halted});
    if (m_known) begin
      chk("ifid_pc", IfIdPC, m_ifpc);
      chk("ifid_instr", IfIdInstr, m_instr);
    end
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", FetchCount, m_fetch);
    chk("bubble_cnt", BubbleCount, m_bubble);
`endif
  endtask

  // One edge: drive inputs, clock, update model, then check off the edge.
  task automatic step(input logic rst, input logic stl,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    Reset = rst; Stall = stl;
    BranchTaken = br; BranchTarget = bt;
    Jump = jp; JumpTarget = jt;
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
    $display("[TB] edge rst=%0b stl=%0b br=%0b bt=%0d jp=%0b jt=%0d -> PC=%0d IfIdPC=%0d V=%0b H=%0b",
             rst, stl, br, bt, jp, jt, PC, IfIdPC, IfIdValid, Halted);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_halted = 0;
    m_known = 1; m_fetch = 0; m_bubble = 0;
    Reset = 1; Stall = 0; BranchTaken = 0; BranchTarget = 0;
    Jump = 0; JumpTarget = 0;

    // Reset for two cycles, then the first fetch.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("first_ifid_pc", IfIdPC, 32'd0);
    chk("first_ifid_instr", IfIdInstr, mem[0]);
    chk("first_pc", PC, 32'd1);

    // Free run.
    step(0, 0, 0, 0, 0, 0);
    chk("run_pc", PC, 32'd2);

    // Stall for three edges at PC=2, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    chk("stall_ifid_pc", IfIdPC, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_release_ifid_pc", IfIdPC, 32'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // Jump and branch on the same edge: the jump wins.
    step(0, 0, 1, 32'd0, 1, 32'd5);
    chk("jump_wins_pc", PC, 32'd5);
    step(0, 0, 0, 0, 0, 0);
    chk("after_jump_ifid_pc", IfIdPC, 32'd5);

    // Run off the end of memory, then hold in HALT.
    for (int i = 0; i < 26; i++) step(0, 0, 0, 0, 0, 0);
    chk("end_ifid_pc", IfIdPC, 32'd31);
    chk("end_halted", {31'd0, Halted}, 32'd1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'd0);
    chk("jump_from_halt_pc", PC, 32'd0);

    // An out-of-range redirect halts; then a reset arrives during a stall.
    step(0, 0, 1, 32'd40, 0, 0);
    chk("oor_pc", PC, 32'd40);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'd7);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'd9, 0, 0);
    chk("reset_mid_pc", PC, 32'd0);

    // Randomized traffic, biased toward the memory boundary.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] t1, t2;
      t1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(28, 45)) : 32'($urandom_range(0, 31));
      t2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(28, 45)) : 32'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), t1,
           ($urandom_range(0, 11) == 0), t2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
